eq_cascade_seq: RTL and testbench

//  Parametrised N-stage cascaded biquad equalizer sequencer, successor to the fixed 5-band chain.

---
 rtl/eq_cascade_seq.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_eq_cascade_seq.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eq_cascade_seq.sv
// Cascaded single-precision biquad equaliser: NSTAGE biquads stepped one at a time, with
// valid/ready sample handshakes, shadow/active coefficient banks and a per-stage bypass.

module filter #(
    parameter int DW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic [DW-1:0] i_b0,
    input  logic [DW-1:0] i_b1,
    input  logic [DW-1:0] i_b2,
    input  logic [DW-1:0] i_a1,
    input  logic [DW-1:0] i_a2,
    input  logic [DW-1:0] i_x0,
    input  logic [DW-1:0] i_x1,
    input  logic [DW-1:0] i_x2,
    output logic [DW-1:0] o_y0,
    output logic [DW-1:0] o_y1,
    output logic [DW-1:0] o_y2
);

    // Denormals flush to zero, rounding is truncation, overflow saturates to infinity.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [47:0] p;
        logic [9:0]  e;
        logic [22:0] m;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 10'd1;
        end else begin
            m = p[45:23];
        end
        if (e[9] || e == 10'd0) return {s, 31'd0};
        if (e >= 10'd255) return {s, 8'hFF, 23'd0};
        return {s, e[7:0], m};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] big;
        logic [31:0] sml;
        logic [7:0]  d;
        logic [26:0] mb;
        logic [26:0] ms;
        logic [26:0] r;
        logic [8:0]  e;
        int          pos;
        if (b[30:23] == 8'd0) return (a[30:23] == 8'd0) ? 32'd0 : a;
        if (a[30:23] == 8'd0) return b;
        if (a[30:0] >= b[30:0]) begin
            big = a;
            sml = b;
        end else begin
            big = b;
            sml = a;
        end
        d  = big[30:23] - sml[30:23];
        mb = {1'b0, 1'b1, big[22:0], 2'b00};
        ms = {1'b0, 1'b1, sml[22:0], 2'b00} >> d;
        e  = {1'b0, big[30:23]};
        if (big[31] == sml[31]) begin
            r = mb + ms;
            if (r[26]) begin
                r = r >> 1;
                e = e + 9'd1;
            end
            if (e >= 9'd255) return {big[31], 8'hFF, 23'd0};
        end else begin
            r = mb - ms;
            if (r == 27'd0) return 32'd0;
            pos = 0;
            for (int i = 0; i < 26; i++) if (r[i]) pos = i;
            r = r << (25 - pos);
            e = e - 9'(25 - pos);
            if (e[8] || e == 9'd0) return 32'd0;
        end
        return {big[31], e[7:0], r[24:2]};
    endfunction

    logic [DW-1:0] y0_q, y1_q, y2_q;
    logic [DW-1:0] y0_d, y1_d, y2_d;
    logic [DW-1:0] acc;

    // y0_q/y1_q hold y[n-1]/y[n-2] until the start pulse commits the new output.
    always_comb begin
        acc  = fp_add(fp_mul(i_b0, i_x0), fp_mul(i_b1, i_x1));
        acc  = fp_add(acc, fp_mul(i_b2, i_x2));
        acc  = fp_add(acc, fp_mul(i_a1, y0_q) ^ 32'h8000_0000);
        acc  = fp_add(acc, fp_mul(i_a2, y1_q) ^ 32'h8000_0000);
        y0_d = y0_q;
        y1_d = y1_q;
        y2_d = y2_q;
        if (i_start) begin
            y0_d = acc;
            y1_d = y0_q;
            y2_d = y1_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            y0_q <= '0;
            y1_q <= '0;
            y2_q <= '0;
        end else begin
            y0_q <= y0_d;
            y1_q <= y1_d;
            y2_q <= y2_d;
        end
    end

    assign o_y0 = y0_q;
    assign o_y1 = y1_q;
    assign o_y2 = y2_q;

endmodule

module eq_cascade_seq #(
    parameter int NSTAGE    = 5,
    parameter int STAGE_LAT = 1,
    parameter int DW        = 32,
    parameter int SW        = (NSTAGE > 1) ? $clog2(NSTAGE) : 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_valid,
    input  logic [DW-1:0] i_data,
    output logic          o_ready,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    input  logic          i_ready,
    input  logic          i_cfg_we,
    input  logic [SW-1:0] i_cfg_stage,
    input  logic [2:0]    i_cfg_sel,
    input  logic [DW-1:0] i_cfg_data,
    input  logic          i_cfg_commit,
    output logic          o_busy,
    output logic          o_cfg_pend
);

    // Handshake: a transfer happens on a clock edge where valid and ready are both high;
    // valid, once raised, stays high with stable data until that edge.

    localparam int CW = (STAGE_LAT > 1) ? $clog2(STAGE_LAT) : 1;
    localparam logic [DW-1:0]   ONE      = DW'(32'h3F80_0000);
    localparam logic [5*DW-1:0] COEF_RST = {{(4*DW){1'b0}}, ONE};

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t                        state_q, state_d;
    logic [SW-1:0]                 idx_q, idx_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic [DW-1:0]                 x0_q, x1_q, x2_q, x0_d, x1_d, x2_d;
    logic                          o_valid_q, o_valid_d;
    logic [DW-1:0]                 o_data_q, o_data_d;
    logic                          cfg_pend_q, cfg_pend_d;
    // Coefficient slot order within a stage: 0=b0 1=b1 2=b2 3=a1 4=a2.
    logic [NSTAGE-1:0][4:0][DW-1:0] sh_coef_q, sh_coef_d, act_coef_q, act_coef_d;
    logic [NSTAGE-1:0]             sh_byp_q, sh_byp_d, act_byp_q, act_byp_d;

    logic                          accept;
    logic                          apply;
    logic                          stage_done;
    logic [NSTAGE-1:0]             start;
    logic [DW-1:0]                 cx0 [NSTAGE+1];
    logic [DW-1:0]                 cx1 [NSTAGE+1];
    logic [DW-1:0]                 cx2 [NSTAGE+1];
    logic                          unused_tail;

    // Shadow bank: out-of-range stage indices and selects above 5 simply match nothing.
    always_comb begin
        sh_coef_d = sh_coef_q;
        sh_byp_d  = sh_byp_q;
        for (int s = 0; s < NSTAGE; s++) begin
            if (i_cfg_we && i_cfg_stage == SW'(s)) begin
                for (int c = 0; c < 5; c++) begin
                    if (i_cfg_sel == 3'(c)) sh_coef_d[s][c] = i_cfg_data;
                end
                if (i_cfg_sel == 3'd5) sh_byp_d[s] = i_cfg_data[0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        x0_d       = x0_q;
        x1_d       = x1_q;
        x2_d       = x2_q;
        o_valid_d  = o_valid_q;
        o_data_d   = o_data_q;
        accept     = (state_q == IDLE) && !cfg_pend_q && i_valid;
        stage_done = act_byp_q[idx_q] || (cnt_q == CW'(STAGE_LAT - 1));
        case (state_q)
            IDLE: begin
                if (accept) begin
                    x0_d    = i_data;
                    x1_d    = x0_q;
                    x2_d    = x1_q;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stage_done) begin
                    cnt_d = '0;
                    if (idx_q == SW'(NSTAGE - 1)) state_d = HOLD;
                    else                          idx_d   = idx_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                // First HOLD cycle captures the settled chain output; later cycles wait for i_ready.
                if (!o_valid_q) begin
                    o_valid_d = 1'b1;
                    o_data_d  = cx0[NSTAGE];
                end else if (i_ready) begin
                    o_valid_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // The active bank only moves in IDLE, and never on the edge that accepts a sample.
        apply      = (state_q == IDLE) && (cfg_pend_q || (i_cfg_commit && !accept));
        cfg_pend_d = apply ? 1'b0 : (cfg_pend_q || i_cfg_commit);
        act_coef_d = apply ? sh_coef_d : act_coef_q;
        act_byp_d  = apply ? sh_byp_d  : act_byp_q;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            x0_q       <= '0;
            x1_q       <= '0;
            x2_q       <= '0;
            o_valid_q  <= 1'b0;
            o_data_q   <= '0;
            cfg_pend_q <= 1'b0;
            sh_coef_q  <= {NSTAGE{COEF_RST}};
            act_coef_q <= {NSTAGE{COEF_RST}};
            sh_byp_q   <= '0;
            act_byp_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            x0_q       <= x0_d;
            x1_q       <= x1_d;
            x2_q       <= x2_d;
            o_valid_q  <= o_valid_d;
            o_data_q   <= o_data_d;
            cfg_pend_q <= cfg_pend_d;
            sh_coef_q  <= sh_coef_d;
            act_coef_q <= act_coef_d;
            sh_byp_q   <= sh_byp_d;
            act_byp_q  <= act_byp_d;
        end
    end

    always_comb begin
        start = '0;
        for (int s = 0; s < NSTAGE; s++) begin
            start[s] = (state_q == RUN) && (idx_q == SW'(s)) && (cnt_q == '0) && !act_byp_q[s];
        end
    end

    assign cx0[0] = x0_q;
    assign cx1[0] = x1_q;
    assign cx2[0] = x2_q;

    for (genvar s = 0; s < NSTAGE; s++) begin : g_stage
        logic [DW-1:0] y0, y1, y2;

        filter #(.DW(DW)) u_filter (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_start (start[s]),
            .i_b0    (act_coef_q[s][0]),
            .i_b1    (act_coef_q[s][1]),
            .i_b2    (act_coef_q[s][2]),
            .i_a1    (act_coef_q[s][3]),
            .i_a2    (act_coef_q[s][4]),
            .i_x0    (cx0[s]),
            .i_x1    (cx1[s]),
            .i_x2    (cx2[s]),
            .o_y0    (y0),
            .o_y1    (y1),
            .o_y2    (y2)
        );

        // A bypassed stage hands its input history straight to the next stage.
        assign cx0[s+1] = act_byp_q[s] ? cx0[s] : y0;
        assign cx1[s+1] = act_byp_q[s] ? cx1[s] : y1;
        assign cx2[s+1] = act_byp_q[s] ? cx2[s] : y2;
    end

    assign unused_tail = ^{cx1[NSTAGE], cx2[NSTAGE]};

    assign o_ready    = (state_q == IDLE) && !cfg_pend_q;
    assign o_valid    = o_valid_q;
    assign o_data     = o_data_q;
    assign o_busy     = (state_q != IDLE);
    assign o_cfg_pend = cfg_pend_q;

endmodule

// File: tb/tb_eq_cascade_seq.sv
// Directed bench for eq_cascade_seq: a default instance (STAGE_LAT=1) and a STAGE_LAT=3
// instance, each driven through its own handshake and configuration tasks.

module tb_eq_cascade_seq;

    localparam logic [31:0] F_HALF = 32'h3F00_0000;
    localparam logic [31:0] F_ONE  = 32'h3F80_0000;
    localparam logic [31:0] F_TWO  = 32'h4000_0000;
    localparam logic [31:0] F_2P5  = 32'h4020_0000;
    localparam logic [31:0] F_THR  = 32'h4040_0000;
    localparam logic [31:0] F_FIVE = 32'h40A0_0000;

    logic        clk;
    logic        rst_n, i_valid, o_ready, o_valid, i_ready;
    logic [31:0] i_data, o_data, cfg_data;
    logic        cfg_we, cfg_commit, o_busy, o_cfg_pend;
    logic [2:0]  cfg_stage, cfg_sel;

    logic        rst3_n, v3, rdy3, ov3, ir3, we3, cm3, busy3, pend3;
    logic [31:0] d3, od3, cd3;
    logic [2:0]  st3, sel3;

    int n_checks = 0;
    int n_fail   = 0;

    eq_cascade_seq u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_data(i_data),
        .o_ready(o_ready), .o_valid(o_valid), .o_data(o_data), .i_ready(i_ready),
        .i_cfg_we(cfg_we), .i_cfg_stage(cfg_stage), .i_cfg_sel(cfg_sel),
        .i_cfg_data(cfg_data), .i_cfg_commit(cfg_commit),
        .o_busy(o_busy), .o_cfg_pend(o_cfg_pend)
    );

    eq_cascade_seq #(.STAGE_LAT(3)) u_dut3 (
        .i_clk(clk), .i_rst_n(rst3_n), .i_valid(v3), .i_data(d3),
        .o_ready(rdy3), .o_valid(ov3), .o_data(od3), .i_ready(ir3),
        .i_cfg_we(we3), .i_cfg_stage(st3), .i_cfg_sel(sel3),
        .i_cfg_data(cd3), .i_cfg_commit(cm3),
        .o_busy(busy3), .o_cfg_pend(pend3)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- drivers: default instance ----------------
    task automatic do_reset();
        rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0; cfg_we = 1'b0; cfg_commit = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic cfg_write(input logic [2:0] stage, input logic [2:0] sel,
                             input logic [31:0] data, input logic commit);
        cfg_we = 1'b1; cfg_stage = stage; cfg_sel = sel; cfg_data = data; cfg_commit = commit;
        @(posedge clk); #1;
        cfg_we = 1'b0; cfg_commit = 1'b0;
    endtask

    task automatic accept(input logic [31:0] d);
        bit ok;
        ok = 1'b0;
        i_valid = 1'b1; i_data = d;
        for (int n = 0; n < 50 && !ok; n++) begin
            ok = o_ready;
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: o_ready=%b required 1", o_ready);
        end
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!o_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic take_output();
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
    endtask

    // ---------------- drivers: STAGE_LAT=3 instance ----------------
    task automatic do_reset3();
        rst3_n = 1'b0; v3 = 1'b0; ir3 = 1'b0; we3 = 1'b0; cm3 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst3_n = 1'b1;
    endtask

    task automatic cfg_write3(input logic [2:0] stage, input logic [2:0] sel,
                              input logic [31:0] data, input logic commit);
        we3 = 1'b1; st3 = stage; sel3 = sel; cd3 = data; cm3 = commit;
        @(posedge clk); #1;
        we3 = 1'b0; cm3 = 1'b0;
    endtask

    task automatic send3(input logic [31:0] d, output int lat, output logic [31:0] got);
        bit ok;
        ok = 1'b0;
        v3 = 1'b1; d3 = d;
        for (int n = 0; n < 50 && !ok; n++) begin
            ok = rdy3;
            @(posedge clk); #1;
        end
        v3 = 1'b0;
        lat = 0;
        while (!ov3 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!ok) lat = -1;
        got = od3;
        ir3 = 1'b1;
        @(posedge clk); #1;
        ir3 = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        n_checks++;
        if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", o_ready); end
        n_checks++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        n_checks++;
        if (o_data !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", o_data); end
        n_checks++;
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        n_checks++;
        if (o_cfg_pend !== 1'b0) begin n_fail++; $display("FAIL reset_pend: got %b want 0", o_cfg_pend); end
    endtask

    task automatic test_identity();
        int lat;
        do_reset();
        accept(F_TWO);
        n_checks++;
        if (o_busy !== 1'b1 || o_ready !== 1'b0) begin
            n_fail++; $display("FAIL ident_busy: busy=%b ready=%b want 1/0", o_busy, o_ready);
        end
        wait_valid(lat);
        n_checks++;
        if (lat !== 6) begin n_fail++; $display("FAIL ident_latency: got %0d want 6", lat); end
        n_checks++;
        if (o_data !== F_TWO) begin n_fail++; $display("FAIL ident_data: got %h want %h", o_data, F_TWO); end
        take_output();
        n_checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            n_fail++; $display("FAIL ident_release: valid=%b ready=%b want 0/1", o_valid, o_ready);
        end
    endtask

    task automatic test_stage_gain();
        int lat;
        do_reset();
        cfg_write(3'd2, 3'd0, F_HALF, 1'b1);
        n_checks++;
        if (o_cfg_pend !== 1'b0) begin n_fail++; $display("FAIL gain_pend: got %b want 0", o_cfg_pend); end
        accept(F_ONE);
        wait_valid(lat);
        n_checks++;
        if (lat !== 6) begin n_fail++; $display("FAIL gain_latency: got %0d want 6", lat); end
        n_checks++;
        if (o_data !== F_HALF) begin n_fail++; $display("FAIL gain_data: got %h want %h", o_data, F_HALF); end
        take_output();
    endtask

    task automatic test_hold();
        int lat;
        do_reset();
        accept(F_TWO);
        wait_valid(lat);
        i_valid = 1'b1; i_data = F_THR;
        for (int c = 0; c < 10; c++) begin
            n_checks++;
            if (o_valid !== 1'b1 || o_data !== F_TWO || o_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: valid=%b data=%h ready=%b want 1/%h/0",
                         c, o_valid, o_data, o_ready, F_TWO);
            end
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        take_output();
        n_checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
            n_fail++; $display("FAIL hold_release: valid=%b busy=%b want 0/0", o_valid, o_busy);
        end
    endtask

    task automatic test_commit_mid_run();
        int lat;
        do_reset();
        accept(F_TWO);
        cfg_write(3'd0, 3'd0, F_HALF, 1'b1);
        n_checks++;
        if (o_cfg_pend !== 1'b1) begin n_fail++; $display("FAIL midrun_pend: got %b want 1", o_cfg_pend); end
        wait_valid(lat);
        n_checks++;
        if (o_data !== F_TWO) begin n_fail++; $display("FAIL midrun_old_data: got %h want %h", o_data, F_TWO); end
        take_output();
        n_checks++;
        if (o_ready !== 1'b0 || o_cfg_pend !== 1'b1) begin
            n_fail++; $display("FAIL midrun_apply_cycle: ready=%b pend=%b want 0/1", o_ready, o_cfg_pend);
        end
        @(posedge clk); #1;
        n_checks++;
        if (o_ready !== 1'b1 || o_cfg_pend !== 1'b0) begin
            n_fail++; $display("FAIL midrun_applied: ready=%b pend=%b want 1/0", o_ready, o_cfg_pend);
        end
        accept(F_TWO);
        wait_valid(lat);
        n_checks++;
        if (o_data !== F_ONE) begin n_fail++; $display("FAIL midrun_new_data: got %h want %h", o_data, F_ONE); end
        take_output();
    endtask

    // Stage 0: y = x[n] + x[n-1]; stage 1: y = x - 0.5*y[n-1].
    // Inputs 1.0, 2.0 -> stage 0 gives 1.0, 3.0 -> stage 1 gives 1.0, 2.5.
    task automatic test_history();
        int lat;
        do_reset();
        cfg_write(3'd0, 3'd1, F_ONE, 1'b0);
        cfg_write(3'd1, 3'd3, F_HALF, 1'b1);
        accept(F_ONE);
        wait_valid(lat);
        n_checks++;
        if (o_data !== F_ONE) begin n_fail++; $display("FAIL hist_first: got %h want %h", o_data, F_ONE); end
        take_output();
        accept(F_TWO);
        wait_valid(lat);
        n_checks++;
        if (o_data !== F_2P5) begin n_fail++; $display("FAIL hist_second: got %h want %h", o_data, F_2P5); end
        take_output();
    endtask

    task automatic test_ignored_writes();
        int lat;
        do_reset();
        cfg_write(3'd7, 3'd0, 32'd0, 1'b0);
        cfg_write(3'd0, 3'd6, 32'd0, 1'b0);
        cfg_write(3'd1, 3'd7, 32'd0, 1'b1);
        accept(F_TWO);
        wait_valid(lat);
        n_checks++;
        if (o_data !== F_TWO) begin n_fail++; $display("FAIL ignored_data: got %h want %h", o_data, F_TWO); end
        take_output();
    endtask

    task automatic test_reset_mid_run();
        int  lat;
        bit  seen;
        do_reset();
        cfg_write(3'd0, 3'd0, F_HALF, 1'b1);
        accept(F_TWO);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_checks++;
        if (o_ready !== 1'b1 || o_busy !== 1'b0 || o_valid !== 1'b0 || o_cfg_pend !== 1'b0) begin
            n_fail++;
            $display("FAIL rstrun_state: ready=%b busy=%b valid=%b pend=%b want 1/0/0/0",
                     o_ready, o_busy, o_valid, o_cfg_pend);
        end
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (o_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL rstrun_no_valid: saw o_valid=%b want 0", seen); end
        accept(F_TWO);
        wait_valid(lat);
        n_checks++;
        if (lat !== 6 || o_data !== F_TWO) begin
            n_fail++; $display("FAIL rstrun_coef: lat=%0d data=%h want 6/%h", lat, o_data, F_TWO);
        end
        take_output();
    endtask

    task automatic test_lat3_bypass();
        int          lat;
        logic [31:0] got;
        do_reset3();
        for (int s = 0; s < 5; s++) cfg_write3(3'(s), 3'd5, 32'd1, (s == 4));
        send3(F_FIVE, lat, got);
        n_checks++;
        if (lat !== 6) begin n_fail++; $display("FAIL lat3_allbyp_latency: got %0d want 6", lat); end
        n_checks++;
        if (got !== F_FIVE) begin n_fail++; $display("FAIL lat3_allbyp_data: got %h want %h", got, F_FIVE); end
        cfg_write3(3'd1, 3'd5, 32'd0, 1'b0);
        cfg_write3(3'd3, 3'd5, 32'd0, 1'b1);
        send3(F_FIVE, lat, got);
        n_checks++;
        if (lat !== 10 || got !== F_FIVE) begin
            n_fail++; $display("FAIL lat3_partial: lat=%0d data=%h want 10/%h", lat, got, F_FIVE);
        end
        do_reset3();
        send3(F_FIVE, lat, got);
        n_checks++;
        if (lat !== 16) begin n_fail++; $display("FAIL lat3_nobyp_latency: got %0d want 16", lat); end
        n_checks++;
        if (got !== F_FIVE) begin n_fail++; $display("FAIL lat3_nobyp_data: got %h want %h", got, F_FIVE); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n = 1'b0; i_valid = 1'b0; i_data = '0; i_ready = 1'b0;
        cfg_we = 1'b0; cfg_stage = '0; cfg_sel = '0; cfg_data = '0; cfg_commit = 1'b0;
        rst3_n = 1'b0; v3 = 1'b0; d3 = '0; ir3 = 1'b0;
        we3 = 1'b0; st3 = '0; sel3 = '0; cd3 = '0; cm3 = 1'b0;
        @(posedge clk); #1;

        test_reset();
        test_identity();
        test_stage_gain();
        test_hold();
        test_commit_mid_run();
        test_history();
        test_ignored_writes();
        test_reset_mid_run();
        test_lat3_bypass();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
